// File: rtl/ldpc_decode_scheduler.sv
// LDPC decode scheduler: load, CNP/VNP iterations, read-out, done.
// Optional early termination on parity_ok: LDPC_SCHED_EARLY_TERM_EN.
module ldpc_decode_scheduler #(
  parameter int L          = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int K          = 6,
  parameter int CNP_LAT    = 5,
  parameter int VNP_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [3:0]            num_iter,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic [ADDR_WIDTH-1:0] load_add,
  output logic [K-1:0]          column_select,
  output logic                  en,
  output logic                  f_id,
  output logic                  dec_reset,
  output logic [ADDR_WIDTH-1:0] read_add,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
`ifdef LDPC_SCHED_EARLY_TERM_EN
  input  logic                  parity_ok,
`endif
  output logic [3:0]            iter_count
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam int MAXLAT = (CNP_LAT > VNP_LAT) ? CNP_LAT : VNP_LAT;
  localparam int PW = $clog2(L + MAXLAT + 1);

  localparam logic [PW-1:0] CNP_END = PW'(L + CNP_LAT - 1);
  localparam logic [PW-1:0] VNP_END = PW'(L + VNP_LAT - 1);
  localparam logic [ADDR_WIDTH-1:0] A_END = ADDR_WIDTH'(L - 1);
  localparam logic [CW-1:0] C_END = CW'(K - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CNP, S_VNP, S_READ, S_DONE
  } state_t;

  state_t state, state_n;

  logic [ADDR_WIDTH-1:0] addr;
  logic [CW-1:0]         col;
  logic [PW-1:0]         cyc;
  logic [3:0]            niter;
  logic [3:0]            iter_inc;
  logic load_xfer, read_xfer, phase_end;
  logic stop, kill, accept;

  always_comb begin
    state_n   = state;
    load_xfer = (state == S_LOAD) && load_valid;
    read_xfer = (state == S_READ) && out_ready;
    phase_end = ((state == S_CNP) && (cyc == CNP_END)) ||
                ((state == S_VNP) && (cyc == VNP_END));
    iter_inc  = iter_count + 4'd1;
    stop      = (iter_inc == niter);
`ifdef LDPC_SCHED_EARLY_TERM_EN
    stop      = stop || parity_ok;
`endif
    kill      = abort && (state != S_IDLE);
    accept    = (state == S_IDLE) && start;
    unique case (state)
      S_IDLE: if (start) state_n = S_LOAD;
      S_LOAD:
        if (load_xfer && col == C_END && addr == A_END)
          state_n = S_CNP;
      S_CNP: if (phase_end) state_n = S_VNP;
      S_VNP:
        if (phase_end) state_n = stop ? S_READ : S_CNP;
      S_READ:
        if (read_xfer && addr == A_END) state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (kill) state_n = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      addr       <= '0;
      col        <= '0;
      cyc        <= '0;
      niter      <= '0;
      iter_count <= '0;
      dec_reset  <= 1'b0;
    end else begin
      state     <= state_n;
      dec_reset <= accept || kill;
      if (state_n != state) cyc <= '0;
      else if (en) cyc <= cyc + PW'(1);
      if (kill) begin
        addr <= '0;
        col  <= '0;
      end else if (accept) begin
        addr       <= '0;
        col        <= '0;
        iter_count <= '0;
        niter      <= (num_iter == 4'd0) ? 4'd1 : num_iter;
      end else if (load_xfer) begin
        addr <= (addr == A_END) ? '0 : addr + ADDR_WIDTH'(1);
        if (addr == A_END)
          col <= (col == C_END) ? '0 : col + CW'(1);
      end else if (read_xfer) begin
        addr <= (addr == A_END) ? '0 : addr + ADDR_WIDTH'(1);
      end else if (state == S_VNP && phase_end) begin
        iter_count <= iter_inc;
      end
    end
  end

  assign busy       = (state != S_IDLE);
  assign load_ready = (state == S_LOAD);
  assign en         = (state == S_CNP) || (state == S_VNP);
  assign f_id       = (state == S_VNP);
  assign out_valid  = (state == S_READ);
  assign done       = (state == S_DONE) && !abort;
  assign load_add   = load_ready ? addr : '0;
  assign read_add   = out_valid ? addr : '0;
  assign column_select = load_ready ? (K'(1) << col) : '0;

endmodule

// File: tb/tb_ldpc_decode_scheduler.sv
// Randomized self-checking bench for ldpc_decode_scheduler.
// Reference: expected transfer order and phase lengths from frame rules.
module tb_ldpc_decode_scheduler;

  localparam int L  = 32;
  localparam int AW = 5;
  localparam int K  = 6;
  localparam int CL = 5;
  localparam int VL = 2;

  logic          clk = 0;
  logic          reset_n = 0;
  logic          start = 0;
  logic          abort = 0;
  logic [3:0]    num_iter = 0;
  logic          load_valid = 0;
  logic          load_ready;
  logic [AW-1:0] load_add;
  logic [K-1:0]  column_select;
  logic          en, f_id, dec_reset;
  logic [AW-1:0] read_add;
  logic          out_valid;
  logic          out_ready = 0;
  logic          busy, done;
  logic [3:0]    iter_count;
`ifdef LDPC_SCHED_EARLY_TERM_EN
  logic          parity_ok = 0;
`endif

  int errors = 0;
  int checks = 0;

  ldpc_decode_scheduler #(
    .L(L), .ADDR_WIDTH(AW), .K(K), .CNP_LAT(CL), .VNP_LAT(VL)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .abort(abort),
    .num_iter(num_iter),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_add(load_add),
    .column_select(column_select),
    .en(en),
    .f_id(f_id),
    .dec_reset(dec_reset),
    .read_add(read_add),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy),
    .done(done),
`ifdef LDPC_SCHED_EARLY_TERM_EN
    .parity_ok(parity_ok),
`endif
    .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One frame: random load/ready pacing, random start/num_iter noise
  // while busy. Optional abort in the second CNP phase, optional
  // early-termination, optional 3-cycle ready stall mid read-out.
  task automatic run_frame(input logic [3:0] ni, input int vpct,
                           input int rpct, input bit et,
                           input bit do_abort, input bit stall3);
    int nload = 0, nread = 0, ndone = 0, cyc = 0, stall = 0;
    int segv[$];
    int segl[$];
    int cur = -1, len = 0, v;
    int last_load = -1, first_en = -1;
    int last_read = -1, done_cyc = -1;
    int passes;
    bit fin = 0;
    logic [K-1:0] onehot;
    passes = et ? 1 : ((ni == 0) ? 1 : int'(ni));

    @(negedge clk);
    start = 1;
    num_iter = ni;
    while (!fin && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      start = 1'($urandom_range(1));
      num_iter = 4'($urandom);
      load_valid = ($urandom_range(99) < vpct);
      out_ready = ($urandom_range(99) < rpct);
      if (stall3 && out_valid && nread == 10 && stall < 3) begin
        out_ready = 0;
        stall++;
      end
      #1;
      if (cyc == 1) begin
        chk("start_dec_reset", dec_reset, 1);
        chk("start_iter_clr", iter_count, 0);
      end
      if (cyc == 2) chk("dec_reset_pulse", dec_reset, 0);
      chk("busy_in_frame", busy, 1);
      if (load_valid && load_ready) begin
        onehot = '0;
        onehot[nload / L] = 1'b1;
        chk("column_select", column_select, onehot);
        chk("load_add", load_add, nload % L);
        nload++;
        last_load = cyc;
      end
      v = en ? int'(f_id) : -1;
      if (v != cur) begin
        if (cur >= 0) begin
          segv.push_back(cur);
          segl.push_back(len);
        end
        cur = v;
        len = 0;
      end
      if (en) len++;
      if (en && first_en < 0) first_en = cyc;
`ifdef LDPC_SCHED_EARLY_TERM_EN
      parity_ok = et && en && f_id && (len == L + VL);
`endif
      if (out_valid && out_ready) begin
        chk("read_add", read_add, nread);
        nread++;
        last_read = cyc;
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
        fin = 1;
      end
      if (do_abort && en && !f_id && segv.size() >= 2 && len == 10) begin
        abort = 1;
        @(negedge clk);
        abort = 0;
        start = 0;
        #1;
        chk("abort_idle", busy, 0);
        chk("abort_dec_reset", dec_reset, 1);
        chk("abort_no_done", done, 0);
        chk("abort_en_off", en, 0);
        @(negedge clk);
        #1;
        chk("abort_dec_reset_end", dec_reset, 0);
        chk("abort_stay_idle", busy, 0);
        chk("abort_no_done2", done, 0);
        return;
      end
    end
    chk("frame_timeout", fin, 1);
    @(negedge clk);
    start = 0;
    load_valid = 0;
    out_ready = 0;
    #1;
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
    chk("iter_count_final", iter_count, passes);
    chk("load_count", nload, K * L);
    chk("read_count", nread, L);
    chk("done_count", ndone, 1);
    chk("cnp_after_load", first_en, last_load + 1);
    chk("done_after_read", done_cyc, last_read + 1);
    chk("phase_count", segv.size(), 2 * passes);
    foreach (segv[i]) begin
      chk("phase_fid", segv[i], i % 2);
      chk("phase_len", segl[i], (i % 2) ? L + VL : L + CL);
    end
    repeat (3) @(negedge clk);
    #1;
    chk("iter_count_hold", iter_count, passes);
  endtask

  initial begin
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_en", en, 0);
    chk("rst_load_ready", load_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dec_reset", dec_reset, 0);
    chk("rst_colsel", column_select, 0);
    chk("rst_iter", iter_count, 0);
    repeat (2) @(negedge clk);
    reset_n = 1;

    run_frame(4'd2, 100, 100, 0, 0, 0);
    run_frame(4'd0, 100, 100, 0, 0, 0);
    run_frame(4'd3, 50, 100, 0, 0, 1);
    run_frame(4'd1, 70, 60, 0, 0, 0);
    run_frame(4'd4, 80, 80, 0, 1, 0);
    run_frame(4'd1, 90, 90, 0, 0, 0);
`ifdef LDPC_SCHED_EARLY_TERM_EN
    run_frame(4'd8, 100, 100, 1, 0, 0);
`endif

    // reset mid-load discards frame
    @(negedge clk);
    start = 1;
    num_iter = 4'd3;
    load_valid = 1;
    @(negedge clk);
    start = 0;
    repeat (20) @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_load_ready", load_ready, 0);
    chk("midrst_load_add", load_add, 0);
    chk("midrst_colsel", column_select, 0);
    chk("midrst_done", done, 0);
    chk("midrst_iter", iter_count, 0);
    @(negedge clk);
    reset_n = 1;
    load_valid = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    #1;
    chk("post_rst_start", busy, 1);
    chk("post_rst_dec_reset", dec_reset, 1);
    abort = 1;
    @(negedge clk);
    abort = 0;
    #1;
    chk("post_rst_abort", busy, 0);

    run_frame(4'd2, 60, 70, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ldpc_decode_scheduler.md
LDPC_DECODE_SCHEDULER -- requirements
Module: ldpc_decode_scheduler

Interface
REQ-001 SHALL have parameter L, default 32, addresses per PE memory (frame depth).
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, log2(L).
REQ-003 SHALL have parameter K, default 6, PE columns.
REQ-004 SHALL have parameter CNP_LAT, default 5, CNU shuffle/CNU/unshuffle pipeline drain cycles.
REQ-005 SHALL have parameter VNP_LAT, default 2, VNU pipeline drain cycles.
REQ-006 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, begin a frame (sampled in IDLE only).
REQ-009 SHALL have port abort, input, 1, abandon the current frame.
REQ-010 SHALL have port num_iter, input, 4, iteration count, latched on accepted start.
REQ-011 SHALL have port load_valid, input, 1, intrinsic sample present.
REQ-012 SHALL have port load_ready, output, 1, scheduler accepts the sample.
REQ-013 SHALL have port load_add, output, ADDR_WIDTH, intrinsic write address.
REQ-014 SHALL have port column_select, output, K, one-hot PE column being loaded.
REQ-015 SHALL have port en, output, 1, decoder processing enable.
REQ-016 SHALL have port f_id, output, 1, phase flag: 0 = check-node phase, 1 = variable-node phase.
REQ-017 SHALL have port dec_reset, output, 1, active-high PE reset pulse.
REQ-018 SHALL have port read_add, output, ADDR_WIDTH, decoded-bit read address.
REQ-019 SHALL have port out_valid / out_ready, output / input, 1 each, read-out handshake.
REQ-020 SHALL have ports busy, done, iter_count, outputs, 1 / 1 / 4, status.

Function
REQ-021 SHALL implement states IDLE, LOAD, CNP, VNP, READ, DONE.
REQ-022 IDLE: start=1 -> LOAD; dec_reset=1 for that one cycle; num_iter latched (0 treated as 1).
REQ-023 LOAD: load_ready=1; a transfer is load_valid&load_ready; column_select=one-hot(col), load_add=addr.
REQ-024 LOAD: addr increments per transfer; wraps L-1 -> 0 with col+1; transfer at (col=K-1, addr=L-1) -> CNP.
REQ-025 CNP: en=1, f_id=0 for exactly L+CNP_LAT cycles, then -> VNP.
REQ-026 VNP: en=1, f_id=1 for exactly L+VNP_LAT cycles; at end iter_count+1; if iter_count equals latched num_iter -> READ, else -> CNP.
REQ-027 READ: out_valid=1, read_add=addr; addr advances only on out_valid&out_ready; transfer at addr=L-1 -> DONE.
REQ-028 DONE: done=1 for exactly one cycle, then -> IDLE.
REQ-029 busy=1 in every state except IDLE; en=0 outside CNP/VNP; load_ready=0 outside LOAD; out_valid=0 outside READ.
REQ-030 start while busy SHALL be ignored; num_iter changes while busy SHALL have no effect.
REQ-031 abort=1 in any non-IDLE state -> IDLE next cycle with dec_reset=1 for one cycle; done not asserted; abort has priority over every other transition.
REQ-032 iter_count SHALL hold its final value in IDLE until the next accepted start clears it to 0.

Reset
REQ-033 reset_n=0 SHALL asynchronously force IDLE, all counters 0, all outputs 0.
REQ-034 reset_n assertion mid-frame SHALL discard the frame with no done pulse.
REQ-035 After reset_n deasserts, the first start SHALL be accepted on the following edge.

Configuration
REQ-036 Macro LDPC_SCHED_EARLY_TERM_EN defined: input parity_ok (1 bit) added; parity_ok=1 on the last VNP cycle -> READ regardless of remaining iterations.
REQ-037 Macro LDPC_SCHED_EARLY_TERM_EN undefined: no parity_ok port; iteration count governed solely by num_iter.

Verification
REQ-038 Reset, start=1, num_iter=2, load_valid held 1 -> exactly 192 load transfers, column_select 000001..100000, load_add 0..31 per column.
REQ-039 Same frame -> en high, f_id pattern 0 (37 cycles), 1 (34), 0 (37), 1 (34); iter_count ends 2; 32 read transfers with out_ready=1; single-cycle done.
REQ-040 num_iter=0 -> exactly one CNP+VNP pass; iter_count=1.
REQ-041 load_valid toggled every other cycle, out_ready low 3 cycles mid-read -> load_add/read_add stall, no address skipped or repeated.
REQ-042 abort during second CNP -> IDLE next cycle, dec_reset one-cycle pulse, done stays 0; start during busy ignored.
REQ-043 LDPC_SCHED_EARLY_TERM_EN, num_iter=8, parity_ok=1 at end of first VNP -> READ entered, iter_count=1.
